// File: rtl/product_divider_if.sv
// Request/result bundle for the restoring product divider.
// The master side issues start/P/M, and the slave side returns Q/R/busy/done/dbz.
interface product_divider_if;
  logic       start;
  logic [7:0] P;
  logic [3:0] M;
  logic [7:0] Q;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       dbz;

  modport master (
    output start, P, M,
    input  Q, R, busy, done, dbz
  );

  modport slave (
    input  start, P, M,
    output Q, R, busy, done, dbz
  );
endinterface

// File: rtl/product_divider.sv
// Divides an 8-bit product by a 4-bit divisor using a multicycle restoring division.
// Each RUN cycle produces one quotient bit, starting with the MSB.
module product_divider (
  input  logic              clk,
  input  logic              rst,
  product_divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [7:0]  dvd;
  logic [3:0]  dvs;
  logic [4:0]  rem;
  logic [2:0]  cnt;
  logic [7:0]  q_r;
  logic [3:0]  r_r;
  logic        busy_r;
  logic        done_r;
  logic        dbz_r;
  logic [12:0] step_nxt;

  // Returns {next_rem[4:0], next_dvd[7:0]}; bit 5 of the trial difference is the borrow.
  function automatic logic [12:0] div_step(input logic [4:0] rem_in,
                                           input logic [7:0] dvd_in,
                                           input logic [3:0] dvs_in);
    logic [5:0] sh;
    logic [5:0] diff;
    logic [4:0] r_n;
    logic       qb;
    sh   = {rem_in, dvd_in[7]};
    diff = sh - {2'b00, dvs_in};
    if (diff[5]) begin
      r_n = sh[4:0];
      qb  = 1'b0;
    end else begin
      r_n = diff[4:0];
      qb  = 1'b1;
    end
    return {r_n, dvd_in[6:0], qb};
  endfunction

  always_comb begin
    step_nxt = div_step(rem, dvd, dvs);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      q_r    <= '0;
      r_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.M != 4'd0) begin
              dvd    <= bus.P;
              dvs    <= bus.M;
              rem    <= '0;
              cnt    <= '0;
              busy_r <= 1'b1;
              state  <= RUN;
            end else begin
              q_r    <= 8'hFF;
              r_r    <= 4'h0;
              dbz_r  <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end
          end
        end
        RUN: begin
          rem <= step_nxt[12:8];
          dvd <= step_nxt[7:0];
          cnt <= cnt + 3'd1;
          // The eighth step completes the quotient, so publish it directly from the step result.
          if (cnt == 3'd7) begin
            q_r    <= step_nxt[7:0];
            r_r    <= step_nxt[11:8];
            dbz_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Q    = q_r;
  assign bus.R    = r_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dbz  = dbz_r;

endmodule

// File: tb/tb_product_divider.sv
// Directed bench for product_divider: nominal, limits, divide-by-zero, ignored start,
// reset abort and an exhaustive back-to-back sweep against the bench's own / and %.
module tb_product_divider;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  product_divider_if bus ();

  product_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_q"},    int'(bus.Q),    0);
    chk({tag, "_r"},    int'(bus.R),    0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_dbz"},  int'(bus.dbz),  0);
  endtask

  // The task issues one request, follows it to done, and leaves the DUT in IDLE for a back-to-back start.
  task automatic run_div(input logic [7:0] p, input logic [3:0] m, input string tag);
    int lat;
    int bcnt;
    int ovl;
    int eq;
    int er;
    int edbz;
    int qi;
    int ri;
    if (m == 4'd0) begin
      eq = 255; er = 0; edbz = 1;
    end else begin
      eq = int'(p) / int'(m); er = int'(p) % int'(m); edbz = 0;
    end
    bus.P = p;
    bus.M = m;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    bus.P = ~p;
    bus.M = m + 4'd1;
    lat  = 0;
    bcnt = bus.busy ? 1 : 0;
    ovl  = (bus.busy && bus.done) ? 1 : 0;
    while (!bus.done && lat < 20) begin
      tick;
      lat++;
      if (bus.busy) bcnt++;
      if (bus.busy && bus.done) ovl++;
    end
    qi = int'(bus.Q);
    ri = int'(bus.R);
    chk({tag, "_lat"},  lat,  (m == 4'd0) ? 0 : 8);
    chk({tag, "_busy"}, bcnt, (m == 4'd0) ? 0 : 8);
    chk({tag, "_ovl"},  ovl,  0);
    chk({tag, "_q"},    qi,   eq);
    chk({tag, "_r"},    ri,   er);
    chk({tag, "_dbz"},  int'(bus.dbz), edbz);
    if (m != 4'd0) begin
      chk({tag, "_ident"}, qi * int'(m) + ri, int'(p));
      chk({tag, "_rltm"},  (ri < int'(m)) ? 1 : 0, 1);
    end
    tick;
    chk({tag, "_pulse"}, int'(bus.done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int dcnt;
    int bcnt;
    bus.start = 1'b0;
    bus.P = 8'd0;
    bus.M = 4'd0;
    rst = 1'b1;
    tick;
    tick;
    chk_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_done", int'(bus.done), 0);
    end

    run_div(8'd225, 4'd15, "nominal");
    run_div(8'd100, 4'd7,  "rem");
    run_div(8'd255, 4'd1,  "max");
    run_div(8'd0,   4'd9,  "zero_p");
    run_div(8'd42,  4'd0,  "dbz");

    for (int i = 0; i < 3; i++) begin
      bus.P = 8'd17 + 8'(i);
      bus.M = 4'd5;
      tick;
    end
    chk("hold_q",   int'(bus.Q),   255);
    chk("hold_dbz", int'(bus.dbz), 1);

    // A second start issued in the third RUN cycle should be ignored.
    bus.P = 8'd143;
    bus.M = 4'd11;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    bus.P = 8'd50;
    bus.M = 4'd3;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    lat = 3;
    while (!bus.done && lat < 20) begin
      tick;
      lat++;
    end
    chk("drop_lat", lat, 8);
    chk("drop_q",   int'(bus.Q), 13);
    chk("drop_r",   int'(bus.R), 0);
    dcnt = 0;
    bcnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick;
      if (bus.done) dcnt++;
      if (bus.busy) bcnt++;
    end
    chk("drop_done", dcnt, 0);
    chk("drop_busy", bcnt, 0);

    // An asynchronous reset in the fourth RUN cycle should abort the division.
    bus.P = 8'd200;
    bus.M = 4'd7;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    tick;
    tick;
    tick;
    chk("pre_abort_busy", int'(bus.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("abort");
    tick;
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (bus.done) dcnt++;
    end
    chk("abort_nodone", dcnt, 0);
    chk("abort_q", int'(bus.Q), 0);
    run_div(8'd9, 4'd2, "post_abort");

    for (int p = 0; p < 256; p++) begin
      for (int m = 1; m < 16; m++) begin
        run_div(8'(p), 4'(m), "sweep");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/product_divider.md
PRODUCT_DIVIDER -- requirements
Module: product_divider

Interface
Parameters: none; all widths are fixed.
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port start, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-004 The block SHALL have port P, input, 8 bits: unsigned dividend, i.e. a 4x4 product.
REQ-005 The block SHALL have port M, input, 4 bits: unsigned divisor.
REQ-006 The block SHALL have port Q, output, 8 bits: registered unsigned quotient.
REQ-007 The block SHALL have port R, output, 4 bits: registered unsigned remainder.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a division is in progress (RUN state).
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when Q/R/dbz become valid.
REQ-010 The block SHALL have port dbz, output, 1 bit: divide-by-zero flag for the latest result.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 The block SHALL, in IDLE with start=1 and M!=0, capture P and M into internal registers at the edge, clear the partial remainder (5 bits) and the 3-bit iteration counter, and move to RUN.
REQ-013 The block SHALL, in IDLE with start=1 and M==0, move to DONE at the edge and load Q=8'hFF, R=4'h0, dbz=1.
REQ-014 The block SHALL perform one restoring-division step per RUN cycle:
 - shift {remainder, dividend} left one bit;
 - if the shifted remainder >= divisor, subtract the divisor and shift in quotient bit 1;
 - otherwise keep the remainder and shift in quotient bit 0.
REQ-015 The block SHALL process quotient bits MSB first, taking exactly 8 RUN cycles.
REQ-016 The block SHALL, on the 8th RUN edge, load Q and R from the working registers, clear dbz, and move to DONE.
REQ-017 The block SHALL assert done for exactly one cycle in DONE, then return to IDLE on the next edge.
REQ-018 Latency SHALL be fixed: start sampled at edge N gives done high in the cycle after edge N+8 for a valid divisor, and after edge N+1 for M==0.
REQ-019 busy SHALL be 1 only in RUN; busy and done SHALL never be high together.
REQ-020 The block SHALL ignore start while in RUN or DONE; a request is neither queued nor restarted.
REQ-021 The block SHALL ignore changes on P and M after capture; results depend only on the values captured.
REQ-022 Q, R and dbz SHALL hold their last values until the next result is loaded.
REQ-023 Results SHALL satisfy P == Q*M + R with R < M for every M!=0 and every P in 0..255.
REQ-024 The block SHALL accept start=1 in the IDLE cycle immediately after DONE, giving back-to-back operations with one idle cycle between them.

Reset
REQ-025 The block SHALL, on rst=1 and regardless of clk, go to IDLE and clear Q, R, busy, done, dbz, the counter and all working registers to 0.
REQ-026 The block SHALL treat reset during RUN or DONE as aborting the operation: no done pulse, and the outputs read zero.
REQ-027 The block SHALL not sample start on the first edge after rst deasserts unless start is high at that edge.

Verification
REQ-028 Nominal: P=8'd225, M=4'd15, start pulsed one cycle -> busy high 8 cycles, then done pulse with Q=15, R=0, dbz=0.
REQ-029 Remainder and limits:
 - P=100, M=7 -> Q=14, R=2.
 - P=255, M=1 -> Q=255, R=0.
 - P=0, M=9 -> Q=0, R=0.
 - Each case has done exactly 8 cycles after the start edge.
REQ-030 Divide by zero: P=8'd42, M=0 -> done on the next cycle with Q=8'hFF, R=0, dbz=1, and busy never asserted.
REQ-031 Start while busy: start P=143, M=11, then assert start with P=50, M=3 on the 3rd RUN cycle -> single done, Q=13, R=0, second request dropped.
REQ-032 Reset mid-operation: assert rst on the 4th RUN cycle -> all outputs 0 immediately, state IDLE, no done; a fresh start with P=9, M=2 then yields Q=4, R=1.
REQ-033 Exhaustive: all 256x15 nonzero pairs, with the checker verifying P == Q*M + R and R < M; back-to-back starts on the cycle after each done.
